// File: rtl/mouse_cmd_scheduler.sv
// Arbitrates two PS/2 mouse command requesters and runs the send/ack handshake
// for a command byte and an optional argument byte, with timeout and resend.
module mouse_cmd_scheduler #(
    parameter int ACK_TIMEOUT = 500000,
    parameter int MAX_RETRY   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [15:0] cmd,
    input  logic [15:0] arg,
    input  logic [1:0]  has_arg,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic        err,
    output logic        busy,
    output logic        send_byte,
    output logic [7:0]  byte_to_send,
    input  logic        byte_sent,
    input  logic        byte_ready,
    input  logic [7:0]  byte_read,
    input  logic [1:0]  byte_error_code
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        WAIT_ACK_CMD,
        SEND_ARG,
        WAIT_ACK_ARG,
        FINISH
    } state_t;

    state_t state, next_state;

    logic [7:0]    cmd_q, arg_q;
    logic          has_arg_q;
    logic [RW-1:0] retry_cnt;
    logic [TW-1:0] timer;
    logic          err_q;
    logic          last_served;

    logic          win;
    logic [7:0]    win_cmd, win_arg;
    logic          ack_good, timed_out, fail, can_retry, entering, strobe_next;

    // Round-robin: on a tie the requester not served last wins.
    always_comb begin
        win = ~last_served;
        if (req == 2'b01) begin
            win = 1'b0;
        end else if (req == 2'b10) begin
            win = 1'b1;
        end
        win_cmd = win ? cmd[15:8] : cmd[7:0];
        win_arg = win ? arg[15:8] : arg[7:0];
    end

    assign ack_good  = byte_ready && (byte_error_code == 2'b00) && (byte_read == 8'hFA);
    assign timed_out = (timer == TIMEOUT_LAST);
    assign can_retry = (retry_cnt < RETRY_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A received byte always wins over a timeout firing in the same cycle.
    always_comb begin
        next_state = state;
        fail       = 1'b0;
        case (state)
            IDLE: begin
                if (|req) next_state = SEND_CMD;
            end
            SEND_CMD: begin
                if (byte_sent)      next_state = WAIT_ACK_CMD;
                else if (timed_out) fail = 1'b1;
            end
            WAIT_ACK_CMD: begin
                if (byte_ready) begin
                    if (ack_good) next_state = has_arg_q ? SEND_ARG : FINISH;
                    else          fail = 1'b1;
                end else if (timed_out) begin
                    fail = 1'b1;
                end
            end
            SEND_ARG: begin
                if (byte_sent)      next_state = WAIT_ACK_ARG;
                else if (timed_out) fail = 1'b1;
            end
            WAIT_ACK_ARG: begin
                if (byte_ready) begin
                    if (ack_good) next_state = FINISH;
                    else          fail = 1'b1;
                end else if (timed_out) begin
                    fail = 1'b1;
                end
            end
            FINISH: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (fail) begin
            if (!can_retry) begin
                next_state = FINISH;
            end else if (state == SEND_CMD || state == WAIT_ACK_CMD) begin
                next_state = SEND_CMD;
            end else begin
                next_state = SEND_ARG;
            end
        end
    end

    // A retry re-enters a SEND state even when already in it, so it counts as an entry.
    always_comb begin
        entering = 1'b0;
        if (next_state == SEND_CMD || next_state == WAIT_ACK_CMD ||
            next_state == SEND_ARG || next_state == WAIT_ACK_ARG) begin
            entering = (next_state != state) || fail;
        end
        strobe_next = entering && (next_state == SEND_CMD || next_state == SEND_ARG);
    end

    assign busy = (state != IDLE);
    assign done = (state == FINISH) ? gnt : 2'b00;
    assign err  = (state == FINISH) && err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt          <= 2'b00;
            cmd_q        <= 8'h00;
            arg_q        <= 8'h00;
            has_arg_q    <= 1'b0;
            retry_cnt    <= '0;
            timer        <= '0;
            err_q        <= 1'b0;
            last_served  <= 1'b1;
            send_byte    <= 1'b0;
            byte_to_send <= 8'hFF;
        end else begin
            send_byte <= strobe_next;

            if (state == IDLE && (|req)) begin
                cmd_q     <= win_cmd;
                arg_q     <= win_arg;
                has_arg_q <= has_arg[win];
                gnt       <= win ? 2'b10 : 2'b01;
                retry_cnt <= '0;
                err_q     <= 1'b0;
            end

            if (strobe_next) begin
                if (state == IDLE)                byte_to_send <= win_cmd;
                else if (next_state == SEND_CMD)  byte_to_send <= cmd_q;
                else                              byte_to_send <= arg_q;
            end

            if (fail && can_retry) begin
                retry_cnt <= retry_cnt + 1'b1;
            end else if (state == WAIT_ACK_CMD && next_state == SEND_ARG) begin
                retry_cnt <= '0;
            end

            if (fail && !can_retry) begin
                err_q <= 1'b1;
            end

            if (entering) begin
                timer <= '0;
            end else if (state != IDLE && state != FINISH) begin
                timer <= timer + 1'b1;
            end

            if (state == FINISH) begin
                gnt         <= 2'b00;
                last_served <= gnt[1];
            end
        end
    end

endmodule

// File: tb/tb_mouse_cmd_scheduler.sv
// Bench for mouse_cmd_scheduler: a scripted transmitter/receiver responder plus a
// transaction-level model that predicts grants, transmitted bytes and completions.
module tb_mouse_cmd_scheduler;

    localparam int ACK_TIMEOUT = 16;
    localparam int MAX_RETRY   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [15:0] cmd, arg;
    logic [1:0]  has_arg;
    logic [1:0]  gnt, done;
    logic        err, busy, send_byte;
    logic [7:0]  byte_to_send;
    logic        byte_sent, byte_ready;
    logic [7:0]  byte_read;
    logic [1:0]  byte_error_code;

    typedef struct {
        bit         present;
        logic [7:0] data;
        logic [1:0] code;
    } reply_t;

    reply_t     script[$];
    reply_t     replies[$];
    logic [7:0] exp_strobe[$];
    logic [1:0] exp_gnt[$];
    logic [2:0] exp_done[$];
    int         gap_q[$];

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         done_seen = 0;
    int         strobe_total = 0;
    int         sent_cyc = -1;
    int         model_last = 1;
    logic [1:0] last_done = 2'b00;
    logic       last_err = 1'b0;
    bit         poke = 1'b0;

    mouse_cmd_scheduler #(.ACK_TIMEOUT(ACK_TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .cmd(cmd), .arg(arg), .has_arg(has_arg),
        .gnt(gnt), .done(done), .err(err), .busy(busy), .send_byte(send_byte),
        .byte_to_send(byte_to_send), .byte_sent(byte_sent), .byte_ready(byte_ready),
        .byte_read(byte_read), .byte_error_code(byte_error_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    task automatic check_fail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: bound expired", name);
    endtask

    task automatic add_reply(input bit present, input logic [7:0] data, input logic [1:0] code);
        reply_t r;
        r.present = present;
        r.data    = data;
        r.code    = code;
        script.push_back(r);
    endtask

    function automatic int pick(input logic [1:0] r);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
        return (model_last == 0) ? 1 : 0;
    endfunction

    // Walk the scripted replies byte by byte: each byte gets up to MAX_RETRY+1
    // attempts, only a clean FA acknowledges it, and an unacknowledged byte ends
    // the transaction with an error.
    task automatic model_txn(input logic [1:0] reqv, input logic [15:0] c16,
                             input logic [15:0] a16, input logic [1:0] ha2);
        int         who;
        bit         bad, ok, ha;
        logic [7:0] c, a;
        reply_t     r;
        who = pick(reqv);
        c   = (who == 1) ? c16[15:8] : c16[7:0];
        a   = (who == 1) ? a16[15:8] : a16[7:0];
        ha  = ha2[who];
        exp_gnt.push_back((who == 1) ? 2'b10 : 2'b01);
        bad = 1'b0;
        for (int b = 0; b < (ha ? 2 : 1) && !bad; b++) begin
            ok = 1'b0;
            for (int att = 0; att <= MAX_RETRY && !ok; att++) begin
                exp_strobe.push_back((b == 0) ? c : a);
                if (script.size() > 0) begin
                    r = script.pop_front();
                end else begin
                    r.present = 1'b0;
                    r.data    = 8'h00;
                    r.code    = 2'b00;
                end
                replies.push_back(r);
                ok = r.present && (r.code == 2'b00) && (r.data == 8'hFA);
            end
            if (!ok) bad = 1'b1;
        end
        exp_done.push_back({((who == 1) ? 2'b10 : 2'b01), bad});
        model_last = who;
    endtask

    // Transmitter/receiver stand-in: BYTE_SENT two cycles after each strobe,
    // then the next scripted reply (or silence) two cycles later.
    initial begin
        reply_t r;
        bit     poked;
        poked           = 1'b0;
        byte_sent       = 1'b0;
        byte_ready      = 1'b0;
        byte_read       = 8'h00;
        byte_error_code = 2'b00;
        forever begin
            @(negedge clk);
            if (poke && !poked) begin
                byte_ready = 1'b1;
                byte_read  = 8'hFA;
                @(negedge clk);
                byte_ready = 1'b0;
                poked      = 1'b1;
            end
            if (!poke) poked = 1'b0;
            while (send_byte && rst_n) begin
                repeat (2) @(negedge clk);
                byte_sent = 1'b1;
                @(negedge clk);
                byte_sent = 1'b0;
                if (replies.size() > 0) begin
                    r = replies.pop_front();
                end else begin
                    r.present = 1'b0;
                    r.data    = 8'h00;
                    r.code    = 2'b00;
                end
                if (r.present) begin
                    repeat (2) @(negedge clk);
                    byte_ready      = 1'b1;
                    byte_read       = r.data;
                    byte_error_code = r.code;
                    @(negedge clk);
                    byte_ready      = 1'b0;
                    byte_error_code = 2'b00;
                end
            end
        end
    end

    // Per-cycle comparison of the DUT against the model's expectation queues.
    initial begin
        logic [1:0] prev_gnt;
        bit         in_send;
        logic [7:0] held;
        prev_gnt = 2'b00;
        in_send  = 1'b0;
        held     = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_gnt = 2'b00;
                in_send  = 1'b0;
                continue;
            end
            check_val("busy_tracks_grant", 32'(busy), 32'(gnt != 2'b00));
            if (prev_gnt == 2'b00 && gnt != 2'b00) begin
                if (exp_gnt.size() == 0) check_fail("unexpected_grant");
                else check_val("grant", 32'(gnt), 32'(exp_gnt.pop_front()));
            end else if (prev_gnt != 2'b00 && gnt != 2'b00) begin
                check_val("grant_held", 32'(gnt), 32'(prev_gnt));
            end
            if (send_byte) begin
                strobe_total++;
                if (exp_strobe.size() == 0) check_fail("unexpected_strobe");
                else check_val("strobe_byte", 32'(byte_to_send), 32'(exp_strobe.pop_front()));
                held    = byte_to_send;
                in_send = 1'b1;
                if (sent_cyc >= 0) gap_q.push_back(cyc - sent_cyc - 1);
            end else if (in_send) begin
                check_val("byte_to_send_stable", 32'(byte_to_send), 32'(held));
            end
            if (in_send && byte_sent) begin
                in_send  = 1'b0;
                sent_cyc = cyc;
            end
            if (done != 2'b00) begin
                done_seen++;
                last_done = done;
                last_err  = err;
                sent_cyc  = -1;
                if (exp_done.size() == 0) check_fail("unexpected_done");
                else check_val("done_err", 32'({done, err}), 32'(exp_done.pop_front()));
            end
            prev_gnt = gnt;
        end
    end

    task automatic run_txn(input logic [1:0] reqv, input int n, input bit hold);
        int target, k;
        target = done_seen + n;
        req    = reqv;
        k = 0;
        while (gnt == 2'b00 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (gnt == 2'b00) check_fail("grant_wait");
        if (!hold) begin
            req     = 2'b00;
            cmd     = ~cmd;
            arg     = ~arg;
            has_arg = ~has_arg;
        end
        k = 0;
        while (done_seen < target && k < 600) begin
            @(negedge clk);
            k++;
        end
        if (done_seen < target) check_fail("done_wait");
        req = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int s0, d0, k;
        rst_n   = 1'b0;
        req     = 2'b00;
        cmd     = 16'h0000;
        arg     = 16'h0000;
        has_arg = 2'b00;
        repeat (3) @(negedge clk);
        check_val("reset_gnt", 32'(gnt), 32'h0);
        check_val("reset_busy", 32'(busy), 32'h0);
        check_val("reset_done", 32'(done), 32'h0);
        check_val("reset_send_byte", 32'(send_byte), 32'h0);
        check_val("reset_byte_to_send", 32'(byte_to_send), 32'hFF);
        rst_n = 1'b1;
        @(negedge clk);

        // Receiver pulse while idle must not start anything.
        poke = 1'b1;
        repeat (4) @(negedge clk);
        poke = 1'b0;
        check_val("idle_ready_busy", 32'(busy), 32'h0);
        check_val("idle_ready_strobes", 32'(strobe_total), 32'h0);

        // Single command, no argument, acked first time.
        cmd = 16'h00FF; arg = 16'h0000; has_arg = 2'b00;
        add_reply(1'b1, 8'hFA, 2'b00);
        model_txn(2'b01, cmd, arg, has_arg);
        check_val("model_single_len", 32'(exp_strobe.size()), 32'd1);
        check_val("model_single_byte", 32'(exp_strobe[0]), 32'hFF);
        check_val("model_single_done", 32'(exp_done[0]), 32'b010);
        run_txn(2'b01, 1, 1'b0);
        check_val("single_done", 32'(last_done), 32'b01);
        check_val("single_err", 32'(last_err), 32'h0);
        check_val("single_strobes", 32'(strobe_total), 32'd1);

        // Requester 1 with an argument byte; inputs scrambled after grant.
        cmd = 16'hF300; arg = 16'h2800; has_arg = 2'b10;
        add_reply(1'b1, 8'hFA, 2'b00);
        add_reply(1'b1, 8'hFA, 2'b00);
        s0 = strobe_total;
        model_txn(2'b10, cmd, arg, has_arg);
        run_txn(2'b10, 1, 1'b0);
        check_val("arg_strobes", 32'(strobe_total - s0), 32'd2);
        check_val("arg_done", 32'(last_done), 32'b10);
        check_val("arg_err", 32'(last_err), 32'h0);

        // Both requesting: alternate grants.
        cmd = 16'hF4E6; arg = 16'h0000; has_arg = 2'b00;
        add_reply(1'b1, 8'hFA, 2'b00);
        add_reply(1'b1, 8'hFA, 2'b00);
        model_txn(2'b11, cmd, arg, has_arg);
        model_txn(2'b11, cmd, arg, has_arg);
        check_val("model_rr_first", 32'(exp_gnt[0]), 32'b01);
        check_val("model_rr_second", 32'(exp_gnt[1]), 32'b10);
        run_txn(2'b11, 2, 1'b1);
        check_val("rr_last_done", 32'(last_done), 32'b10);

        // FE on every attempt: three strobes then error.
        cmd = 16'h00FF; has_arg = 2'b00;
        repeat (3) add_reply(1'b1, 8'hFE, 2'b00);
        s0 = strobe_total;
        model_txn(2'b01, cmd, arg, has_arg);
        check_val("model_fe_len", 32'(exp_strobe.size()), 32'd3);
        run_txn(2'b01, 1, 1'b0);
        check_val("fe_strobes", 32'(strobe_total - s0), 32'd3);
        check_val("fe_err", 32'(last_err), 32'h1);

        // Receiver error code on an FA counts as a failure, then a clean ack.
        cmd = 16'hF200; has_arg = 2'b00;
        add_reply(1'b1, 8'hFA, 2'b01);
        add_reply(1'b1, 8'hFA, 2'b00);
        s0 = strobe_total;
        model_txn(2'b10, cmd, arg, has_arg);
        run_txn(2'b10, 1, 1'b0);
        check_val("code_strobes", 32'(strobe_total - s0), 32'd2);
        check_val("code_err", 32'(last_err), 32'h0);

        // Both bytes use all retries; the count restarts for the argument.
        cmd = 16'h00E8; arg = 16'h0003; has_arg = 2'b01;
        repeat (2) add_reply(1'b1, 8'hFE, 2'b00);
        add_reply(1'b1, 8'hFA, 2'b00);
        repeat (2) add_reply(1'b1, 8'hFE, 2'b00);
        add_reply(1'b1, 8'hFA, 2'b00);
        s0 = strobe_total;
        model_txn(2'b01, cmd, arg, has_arg);
        run_txn(2'b01, 1, 1'b0);
        check_val("retry_clear_strobes", 32'(strobe_total - s0), 32'd6);
        check_val("retry_clear_err", 32'(last_err), 32'h0);

        // Silence: each ack window lasts ACK_TIMEOUT cycles, error after three.
        cmd = 16'hF400; has_arg = 2'b00;
        repeat (3) add_reply(1'b0, 8'h00, 2'b00);
        gap_q.delete();
        model_txn(2'b10, cmd, arg, has_arg);
        run_txn(2'b10, 1, 1'b0);
        check_val("timeout_gap_count", 32'(gap_q.size()), 32'd2);
        if (gap_q.size() >= 2) begin
            check_val("timeout_gap_1", 32'(gap_q[0]), 32'(ACK_TIMEOUT));
            check_val("timeout_gap_2", 32'(gap_q[1]), 32'(ACK_TIMEOUT));
        end
        check_val("timeout_err", 32'(last_err), 32'h1);

        // Reset while waiting for the argument ack.
        cmd = 16'h00F3; arg = 16'h0064; has_arg = 2'b01;
        exp_gnt.push_back(2'b01);
        exp_strobe.push_back(8'hF3);
        exp_strobe.push_back(8'h64);
        add_reply(1'b1, 8'hFA, 2'b00);
        add_reply(1'b0, 8'h00, 2'b00);
        replies.push_back(script.pop_front());
        replies.push_back(script.pop_front());
        s0  = strobe_total;
        d0  = done_seen;
        req = 2'b01;
        k = 0;
        while (strobe_total < s0 + 2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (strobe_total < s0 + 2) check_fail("arg_strobe_wait");
        req = 2'b00;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #2;
        check_val("abort_gnt", 32'(gnt), 32'h0);
        check_val("abort_busy", 32'(busy), 32'h0);
        check_val("abort_send_byte", 32'(send_byte), 32'h0);
        check_val("abort_byte_to_send", 32'(byte_to_send), 32'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 1;
        repeat (3) @(negedge clk);
        check_val("abort_no_done", 32'(done_seen), 32'(d0));

        cmd = 16'h00FF; has_arg = 2'b00;
        add_reply(1'b1, 8'hFA, 2'b00);
        model_txn(2'b01, cmd, arg, has_arg);
        run_txn(2'b01, 1, 1'b0);
        check_val("post_reset_done", 32'(last_done), 32'b01);

        check_val("left_strobes", 32'(exp_strobe.size()), 32'd0);
        check_val("left_dones", 32'(exp_done.size()), 32'd0);
        check_val("left_grants", 32'(exp_gnt.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog");
    end

endmodule
